// File: rtl/xgmii64_to_32_pkg.sv
`default_nettype none
// ============================================================================
// Package : gtype / xgmii64_to_32_pkg
// Brief   : XGMII bus types, control codes, and 64->32 converter helpers.
// Revision: 1.0 - initial release
// ============================================================================

package gtype;

  typedef struct packed {
    logic        ena;
    logic [7:0]  ctrl;
    logic [63:0] data;
  } xgmii64_t;

  typedef struct packed {
    logic        ena;
    logic [3:0]  ctrl;
    logic [31:0] data;
  } xgmii32_t;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;

  localparam xgmii32_t XGMII32_IDLE = '{ena: 1'b0, ctrl: 4'hF, data: 32'h07070707};

endpackage

package xgmii64_to_32_pkg;

  import gtype::*;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_t;

  localparam int unsigned CHK_STATE_W = 1;
  localparam logic [CHK_STATE_W-1:0] CHK_IDLE = 1'b0;
  localparam logic [CHK_STATE_W-1:0] CHK_DATA = 1'b1;

  typedef struct packed {
    logic [CHK_STATE_W-1:0] state;
    logic                   illegal;
  } lane_res_t;

  // Lane-serial frame rule; an illegal lane always drops the checker back to IDLE.
  function automatic lane_res_t lane_check(
    input logic [CHK_STATE_W-1:0] state,
    input logic                   is_ctrl,
    input logic [7:0]             code,
    input logic                   first_lane
  );
    lane_res_t r;
    r.state   = state;
    r.illegal = 1'b0;
    if (is_ctrl) begin
      if (state == CHK_IDLE) begin
        case (code)
          XGMII_START: begin
            if (first_lane) r.state   = CHK_DATA;
            else            r.illegal = 1'b1;
          end
          XGMII_IDLE, XGMII_TERM, XGMII_ERROR, XGMII_SEQ: r.illegal = 1'b0;
          default: r.illegal = 1'b1;
        endcase
      end else begin
        case (code)
          XGMII_TERM:  r.state   = CHK_IDLE;
          XGMII_ERROR: r.illegal = 1'b0;
          default:     r.illegal = 1'b1;
        endcase
      end
      if (r.illegal) r.state = CHK_IDLE;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xgmii64_to_32_if.sv
`default_nettype none
// ============================================================================
// Interface: xgmii64_to_32_if
// Brief    : 64-bit XGMII input with ready, 32-bit XGMII output and error flag.
// Revision : 1.0 - initial release
// ============================================================================

interface xgmii64_to_32_if;

  import gtype::*;

  xgmii64_t in64;
  logic     in_rdy;
  xgmii32_t out32;
  logic     err;

  modport master (output in64, input in_rdy, input out32, input err);
  modport slave  (input in64, output in_rdy, output out32, output err);

endinterface

`default_nettype wire

// File: rtl/xgmii64_to_32_frame_check.sv
`default_nettype none
// ============================================================================
// Module  : xgmii32_frame_check
// Brief   : Per-beat 32-bit XGMII frame checker; illegal lanes become Error.
// Revision: 1.0 - initial release
// ============================================================================

module xgmii32_frame_check
  import gtype::*;
  import xgmii64_to_32_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire xgmii32_t i_beat,
  output xgmii32_t      o_beat,
  output logic          o_err
);

  logic [CHK_STATE_W-1:0] r_state;
  logic [CHK_STATE_W-1:0] w_state_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= CHK_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin : p_next_state
    lane_res_t              v_res;
    logic [CHK_STATE_W-1:0] v_st;
    v_st  = r_state;
    v_res = '0;
    if (i_beat.ena) begin
      for (int i = 0; i < 4; i++) begin
        v_res = lane_check(v_st, i_beat.ctrl[i], i_beat.data[8*i +: 8], (i == 0));
        v_st  = v_res.state;
      end
    end
    w_state_nxt = v_st;
  end

  always_comb begin : p_output
    lane_res_t              v_res;
    logic [CHK_STATE_W-1:0] v_st;
    v_st   = r_state;
    v_res  = '0;
    o_beat = i_beat;
    o_err  = 1'b0;
    if (i_beat.ena) begin
      for (int i = 0; i < 4; i++) begin
        v_res = lane_check(v_st, i_beat.ctrl[i], i_beat.data[8*i +: 8], (i == 0));
        if (v_res.illegal) begin
          o_beat.ctrl[i]          = 1'b1;
          o_beat.data[8*i +: 8]   = XGMII_ERROR;
          o_err                   = 1'b1;
        end
        v_st = v_res.state;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xgmii64_to_32.sv
`default_nettype none
// ============================================================================
// Module  : xgmii64_to_32
// Brief   : 64-bit to 32-bit XGMII down-converter (lanes 0-3 then 4-7).
//           Define XGMII64TO32_CHECK_EN to add the output frame checker.
// Revision: 1.0 - initial release
// ============================================================================

module xgmii64_to_32
  import gtype::*;
  import xgmii64_to_32_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  xgmii64_to_32_if.slave  bus
);

  logic     r_wrk_valid;
  half_t    r_wrk_half;
  xgmii64_t r_wrk_word;
  logic     r_skd_valid;
  xgmii64_t r_skd_word;
  xgmii32_t r_out;
  logic     r_err;

  logic     w_accept;
  logic     w_wrk_free;
  xgmii32_t w_beat;
  xgmii32_t w_beat_chk;
  logic     w_err;

  // Ready depends only on skid occupancy, so the input never sees a comb path.
  assign bus.in_rdy = ~r_skd_valid;
  assign w_accept   = bus.in64.ena & ~r_skd_valid;
  assign w_wrk_free = ~r_wrk_valid | ((r_wrk_half == HALF_HI) & ~r_skd_valid);

  always_comb begin
    w_beat = XGMII32_IDLE;
    if (r_wrk_valid) begin
      w_beat.ena = r_wrk_word.ena;
      if (r_wrk_half == HALF_HI) begin
        w_beat.ctrl = r_wrk_word.ctrl[7:4];
        w_beat.data = r_wrk_word.data[63:32];
      end else begin
        w_beat.ctrl = r_wrk_word.ctrl[3:0];
        w_beat.data = r_wrk_word.data[31:0];
      end
    end
  end

`ifdef XGMII64TO32_CHECK_EN
  xgmii32_frame_check u_frame_check (
    .clk    (clk),
    .rst    (rst),
    .i_beat (w_beat),
    .o_beat (w_beat_chk),
    .o_err  (w_err)
  );
`else
  assign w_beat_chk = w_beat;
  assign w_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrk_valid <= 1'b0;
      r_wrk_half  <= HALF_LO;
      r_wrk_word  <= '0;
      r_skd_valid <= 1'b0;
      r_skd_word  <= '0;
      r_out       <= XGMII32_IDLE;
      r_err       <= 1'b0;
    end else begin
      r_out <= w_beat_chk;
      r_err <= w_err;

      if (r_wrk_valid && (r_wrk_half == HALF_LO)) begin
        r_wrk_half <= HALF_HI;
      end else if (r_wrk_valid && r_skd_valid) begin
        r_wrk_word  <= r_skd_word;
        r_wrk_half  <= HALF_LO;
        r_skd_valid <= 1'b0;
      end else if (w_accept) begin
        r_wrk_valid <= 1'b1;
        r_wrk_word  <= bus.in64;
        r_wrk_half  <= HALF_LO;
      end else if (r_wrk_valid) begin
        r_wrk_valid <= 1'b0;
      end

      if (w_accept && !w_wrk_free) begin
        r_skd_valid <= 1'b1;
        r_skd_word  <= bus.in64;
      end
    end
  end

  assign bus.out32 = r_out;
  assign bus.err   = r_err;

endmodule

`default_nettype wire
